// File: rtl/mem_shaper_pkg.sv
// Shared types and default widths for the memory bandwidth shaper and its
// companion switch monitor.
package mem_shaper_pkg;

    localparam int PCW_DEF          = 10;  // fraction bits of monitor rates (1.0 = 2^PCW)
    localparam int TOKEN_WIDTH_DEF  = 20;
    localparam int WEIGHT_WIDTH_DEF = 4;

    // Per-channel address-phase state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COST = 2'd1,
        WAIT = 2'd2,
        PASS = 2'd3
    } chan_state_e;

    // Round-robin pointer: which channel wins when both are eligible.
    typedef enum logic {
        RR_AR = 1'b0,
        RR_AW = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/mem_bw_shaper_if.sv
// AR/AW address-channel handshake bundle. Only valid/ready and the burst
// length pass through the shaper; addresses travel beside it.
interface mem_bw_shaper_if;

    logic [7:0] s_arlen;
    logic [7:0] s_awlen;
    logic       s_arvalid;
    logic       s_awvalid;
    logic       s_arready;
    logic       s_awready;
    logic       m_arvalid;
    logic       m_awvalid;
    logic       m_arready;
    logic       m_awready;

    // Shaper view: tenant request in, memory-side request out.
    modport slave (
        input  s_arlen, s_awlen, s_arvalid, s_awvalid, m_arready, m_awready,
        output s_arready, s_awready, m_arvalid, m_awvalid
    );

    // Environment view: tenant master plus memory-side responder.
    modport master (
        output s_arlen, s_awlen, s_arvalid, s_awvalid, m_arready, m_awready,
        input  s_arready, s_awready, m_arvalid, m_awvalid
    );

endinterface

// File: rtl/mem_shaper_chan.sv
// One address channel: latches the request, prices it from the monitored
// miss/turnaround rates, waits for a grant, then forwards the handshake.
module mem_shaper_chan
    import mem_shaper_pkg::*;
#(
    parameter int PCW          = PCW_DEF,
    parameter int TOKEN_WIDTH  = TOKEN_WIDTH_DEF,
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_valid,
    input  logic [7:0]              s_len,
    output logic                    s_ready,
    output logic                    m_valid,
    input  logic                    m_ready,
    input  logic [PCW:0]            rd_wr_switch,
    input  logic [PCW:0]            miss_rate,
    input  logic [WEIGHT_WIDTH-1:0] miss_weight,
    input  logic [WEIGHT_WIDTH-1:0] switch_weight,
    input  logic                    grant,
    output logic                    waiting,
    output logic [TOKEN_WIDTH-1:0]  cost
);

    // factor = 1.0 + two (PCW+1)x(WEIGHT_WIDTH) products: three extra bits cover the sum.
    localparam int FW  = PCW + WEIGHT_WIDTH + 3;
    localparam int PW  = FW + 9;                  // (len+1) is 9 bits
    localparam int SW  = PW - PCW;                // width after the fixed-point shift
    localparam int CW  = (SW > TOKEN_WIDTH) ? SW : TOKEN_WIDTH;
    localparam int CXW = CW + 1;
    localparam logic [TOKEN_WIDTH-1:0] TOKEN_MAX = '1;

    chan_state_e            state_q, state_d;
    logic [7:0]             len_q;
    logic [PCW:0]           miss_q;
    logic [PCW:0]           switch_q;
    logic [TOKEN_WIDTH-1:0] cost_q;

    logic [FW-1:0]          factor;
    logic [PW-1:0]          product;
    logic [CXW-1:0]         cost_ext;
    logic [TOKEN_WIDTH-1:0] cost_sat;

    // Cost from the latched request: ((len+1)*factor) >> PCW, saturated.
    assign factor   = (FW'(1) << PCW)
                    + FW'(miss_q) * FW'(miss_weight)
                    + FW'(switch_q) * FW'(switch_weight);
    assign product  = (PW'(len_q) + PW'(1)) * PW'(factor);
    assign cost_ext = CXW'(product >> PCW);
    assign cost_sat = (cost_ext > CXW'(TOKEN_MAX)) ? TOKEN_MAX : cost_ext[TOKEN_WIDTH-1:0];
    assign cost     = cost_q;

    // State register.
    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Request capture and cost registration.
    always_ff @(posedge aclk) begin
        // NOTE: datapath registers carry no reset; they are only read in
        // states entered after they have been loaded.
        if (state_q == IDLE && s_valid) begin
            len_q    <= s_len;
            miss_q   <= miss_rate;
            switch_q <= rd_wr_switch;
        end
        if (state_q == COST) cost_q <= cost_sat;
    end

    // Next state and handshake outputs.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d = state_q;
        m_valid = 1'b0;
        s_ready = 1'b0;
        waiting = 1'b0;
        unique case (state_q)
            IDLE: if (s_valid) state_d = COST;
            COST: state_d = WAIT;
            WAIT: begin
                waiting = 1'b1;
                if (grant) state_d = PASS;
            end
            PASS: begin
                m_valid = 1'b1;
                s_ready = m_ready;
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/mem_bw_shaper.sv
// Per-tenant AR/AW bandwidth shaper: a token bucket shared by both address
// channels with a round-robin grant when both can afford to go.
module mem_bw_shaper
    import mem_shaper_pkg::*;
#(
    parameter int PARAM_COUNT_WIDTH = PCW_DEF,
    parameter int TOKEN_WIDTH       = TOKEN_WIDTH_DEF,
    parameter int WEIGHT_WIDTH      = WEIGHT_WIDTH_DEF
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [PARAM_COUNT_WIDTH:0]   rd_wr_switch,
    input  logic [PARAM_COUNT_WIDTH:0]   miss_rate,
    input  logic                         throttle_en,
    input  logic [TOKEN_WIDTH-1:0]       refill_rate,
    input  logic [TOKEN_WIDTH-1:0]       bucket_max,
    input  logic [WEIGHT_WIDTH-1:0]      miss_weight,
    input  logic [WEIGHT_WIDTH-1:0]      switch_weight,
    mem_bw_shaper_if.slave               axi,
    output logic [TOKEN_WIDTH-1:0]       tokens
);

    logic                   ar_waiting, aw_waiting;
    logic [TOKEN_WIDTH-1:0] ar_cost, aw_cost;
    logic [TOKEN_WIDTH-1:0] ar_need, aw_need;
    logic                   ar_elig, aw_elig;
    logic                   ar_grant, aw_grant;
    logic                   rr_flip;
    rr_sel_e                rr_ptr;
    logic [TOKEN_WIDTH-1:0] debit;
    logic [TOKEN_WIDTH:0]   token_sum;
    logic [TOKEN_WIDTH-1:0] tokens_nxt;

    function automatic logic [TOKEN_WIDTH-1:0] tok_min(input logic [TOKEN_WIDTH-1:0] a,
                                                       input logic [TOKEN_WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    mem_shaper_chan #(
        .PCW(PARAM_COUNT_WIDTH), .TOKEN_WIDTH(TOKEN_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH)
    ) u_ar_chan (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(axi.s_arvalid), .s_len(axi.s_arlen), .s_ready(axi.s_arready),
        .m_valid(axi.m_arvalid), .m_ready(axi.m_arready),
        .rd_wr_switch(rd_wr_switch), .miss_rate(miss_rate),
        .miss_weight(miss_weight), .switch_weight(switch_weight),
        .grant(ar_grant), .waiting(ar_waiting), .cost(ar_cost)
    );

    mem_shaper_chan #(
        .PCW(PARAM_COUNT_WIDTH), .TOKEN_WIDTH(TOKEN_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH)
    ) u_aw_chan (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(axi.s_awvalid), .s_len(axi.s_awlen), .s_ready(axi.s_awready),
        .m_valid(axi.m_awvalid), .m_ready(axi.m_awready),
        .rd_wr_switch(rd_wr_switch), .miss_rate(miss_rate),
        .miss_weight(miss_weight), .switch_weight(switch_weight),
        .grant(aw_grant), .waiting(aw_waiting), .cost(aw_cost)
    );

    // A cost above the bucket limit is capped so it can still be served from a full bucket.
    assign ar_need = tok_min(ar_cost, bucket_max);
    assign aw_need = tok_min(aw_cost, bucket_max);
    assign ar_elig = ar_waiting && (!throttle_en || tokens >= ar_need);
    assign aw_elig = aw_waiting && (!throttle_en || tokens >= aw_need);

    // Single-grant arbiter and debit selection.
    always_comb begin
        ar_grant = 1'b0;
        aw_grant = 1'b0;
        rr_flip  = 1'b0;
        debit    = '0;
        if (ar_elig && aw_elig) begin
            rr_flip = 1'b1;
            if (rr_ptr == RR_AR) ar_grant = 1'b1;
            else                 aw_grant = 1'b1;
        end else begin
            ar_grant = ar_elig;
            aw_grant = aw_elig;
        end
        if (throttle_en) begin
            if (ar_grant)      debit = ar_need;
            else if (aw_grant) debit = aw_need;
        end
    end

    // Debit never exceeds tokens (eligibility), so the one-bit-wider sum cannot underflow.
    assign token_sum  = {1'b0, tokens} + {1'b0, refill_rate} - {1'b0, debit};
    assign tokens_nxt = (token_sum > {1'b0, bucket_max}) ? bucket_max : token_sum[TOKEN_WIDTH-1:0];

    // Token bucket and round-robin pointer.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tokens <= '0;
            rr_ptr <= RR_AR;
        end else begin
            tokens <= tokens_nxt;
            if (rr_flip) rr_ptr <= (rr_ptr == RR_AR) ? RR_AW : RR_AR;
        end
    end

endmodule

// File: tb/tb_mem_bw_shaper.sv
// Self-checking bench for mem_bw_shaper. All stimulus is driven and all
// outputs sampled on the falling clock edge.
module tb_mem_bw_shaper;
    import mem_shaper_pkg::*;

    localparam int PCW = 10;
    localparam int TW  = 20;
    localparam int WW  = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [PCW:0]  rd_wr_switch = '0;
    logic [PCW:0]  miss_rate = '0;
    logic          throttle_en = 1'b1;
    logic [TW-1:0] refill_rate = TW'(4);
    logic [TW-1:0] bucket_max = TW'(1000);
    logic [WW-1:0] miss_weight = '0;
    logic [WW-1:0] switch_weight = '0;
    logic [TW-1:0] tokens;

    mem_bw_shaper_if bus ();

    mem_bw_shaper #(.PARAM_COUNT_WIDTH(PCW), .TOKEN_WIDTH(TW), .WEIGHT_WIDTH(WW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_wr_switch(rd_wr_switch), .miss_rate(miss_rate),
        .throttle_en(throttle_en), .refill_rate(refill_rate), .bucket_max(bucket_max),
        .miss_weight(miss_weight), .switch_weight(switch_weight),
        .axi(bus), .tokens(tokens)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    // Scoreboard entry: channel (0 = AR, 1 = AW) and expected debit/cost.
    typedef struct {
        bit is_aw;
        int value;
    } exp_t;
    exp_t sb[$];

    // Drive one request at the current falling edge and wait for its PASS.
    // lat counts rising edges after the one that sampled s_valid.
    task automatic issue(input bit is_aw, input logic [7:0] len, input int budget,
                         input bit perturb, output bit seen, output int lat,
                         output int tok_before, output int tok_after, output bit rdy);
        seen = 1'b0; lat = -1; tok_before = int'(tokens); tok_after = 0; rdy = 1'b0;
        if (is_aw) begin bus.s_awlen = len; bus.s_awvalid = 1'b1; end
        else       begin bus.s_arlen = len; bus.s_arvalid = 1'b1; end
        for (int i = 1; i <= budget; i++) begin
            @(negedge aclk);
            if (perturb && i == 1) begin
                miss_rate    = '1;
                rd_wr_switch = '1;
            end
            if (is_aw ? bus.m_awvalid : bus.m_arvalid) begin
                seen      = 1'b1;
                lat       = i - 1;
                tok_after = int'(tokens);
                rdy       = is_aw ? bus.s_awready : bus.s_arready;
                break;
            end
            tok_before = int'(tokens);
        end
        bus.s_arvalid = 1'b0;
        bus.s_awvalid = 1'b0;
        if (seen) @(negedge aclk);
    endtask

    task automatic test_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0;
        bus.s_arlen = '0; bus.s_awlen = '0;
        bus.m_arready = 1'b1; bus.m_awready = 1'b1;
        repeat (2) @(negedge aclk);
        checks++;
        if (tokens !== '0) begin
            errors++; $display("FAIL reset_tokens: got %0d expected 0", tokens);
        end
        checks++;
        if ({bus.m_arvalid, bus.m_awvalid, bus.s_arready, bus.s_awready} !== 4'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 0000",
                     {bus.m_arvalid, bus.m_awvalid, bus.s_arready, bus.s_awready});
        end
    endtask

    // Bucket fills 0,4,8,12,16 from release; grant on the cycle it reads 16.
    task automatic test_cost_basic();
        bit seen, rdy; int lat, tb4, ta; exp_t e;
        aresetn = 1'b1;
        sb.push_back('{is_aw: 1'b0, value: 16});
        issue(1'b0, 8'd15, 30, 1'b0, seen, lat, tb4, ta, rdy);
        e = sb.pop_front();
        checks++;
        if (!seen) begin errors++; $display("FAIL basic_pass: m_arvalid not seen within budget"); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        checks++;
        if (tb4 !== 16) begin errors++; $display("FAIL basic_tokens_at_grant: got %0d expected 16", tb4); end
        checks++;
        if (ta !== 4) begin errors++; $display("FAIL basic_tokens_after: got %0d expected 4", ta); end
        checks++;
        if (tb4 + 4 - ta !== e.value) begin
            errors++; $display("FAIL basic_cost: got %0d expected %0d", tb4 + 4 - ta, e.value);
        end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL basic_s_arready: got %b expected 1", rdy); end
    endtask

    task automatic test_penalty();
        bit seen, rdy; int lat, tb4, ta; exp_t e;
        repeat (10) @(negedge aclk);
        // factor = 1024 + 512*2 = 2048 -> cost = 8*2 = 16; monitor changes in COST are ignored.
        miss_rate = 11'd512; miss_weight = 4'd2; rd_wr_switch = '0; switch_weight = '0;
        sb.push_back('{is_aw: 1'b0, value: 16});
        issue(1'b0, 8'd7, 20, 1'b1, seen, lat, tb4, ta, rdy);
        e = sb.pop_front();
        checks++;
        if (!seen || lat !== 2) begin
            errors++; $display("FAIL miss_latency: got seen=%0b lat=%0d expected seen=1 lat=2", seen, lat);
        end
        checks++;
        if (tb4 + 4 - ta !== e.value) begin
            errors++; $display("FAIL miss_cost: got %0d expected %0d", tb4 + 4 - ta, e.value);
        end
        // factor = 1024 + 1024*1 = 2048 -> cost = 1*2 = 2.
        miss_rate = '0; miss_weight = '0; rd_wr_switch = 11'd1024; switch_weight = 4'd1;
        sb.push_back('{is_aw: 1'b1, value: 2});
        issue(1'b1, 8'd0, 20, 1'b0, seen, lat, tb4, ta, rdy);
        e = sb.pop_front();
        checks++;
        if (!seen || tb4 + 4 - ta !== e.value) begin
            errors++; $display("FAIL switch_cost: got %0d (seen=%0b) expected %0d", tb4 + 4 - ta, seen, e.value);
        end
        rd_wr_switch = '0; switch_weight = '0;
    endtask

    task automatic test_back_to_back();
        int hits[$];
        bus.s_arlen = 8'd0; bus.s_arvalid = 1'b1;
        for (int i = 0; i < 30 && hits.size() < 4; i++) begin
            @(negedge aclk);
            if (bus.m_arvalid) begin
                hits.push_back(i);
                if (hits.size() == 4) bus.s_arvalid = 1'b0;
            end
        end
        bus.s_arvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if (hits.size() !== 4) begin
            errors++; $display("FAIL b2b_count: got %0d passes expected 4", hits.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (hits[k] - hits[k-1] !== 4) begin
                    errors++; $display("FAIL b2b_spacing: got %0d cycles expected 4", hits[k] - hits[k-1]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int got, overlap; exp_t e;
        overlap = 0;
        for (int r = 0; r < 4; r++) begin
            sb.push_back('{is_aw: bit'(r % 2), value: 0});
            sb.push_back('{is_aw: bit'((r + 1) % 2), value: 0});
            bus.s_arlen = 8'd0; bus.s_awlen = 8'd0;
            bus.s_arvalid = 1'b1; bus.s_awvalid = 1'b1;
            got = 0;
            for (int i = 0; i < 20 && got < 2; i++) begin
                @(negedge aclk);
                if (bus.m_arvalid && bus.m_awvalid) overlap++;
                if (bus.m_arvalid) begin
                    e = sb.pop_front(); got++; bus.s_arvalid = 1'b0;
                    checks++;
                    if (e.is_aw !== 1'b0) begin
                        errors++; $display("FAIL rr_order round %0d: got AR expected AW", r);
                    end
                end else if (bus.m_awvalid) begin
                    e = sb.pop_front(); got++; bus.s_awvalid = 1'b0;
                    checks++;
                    if (e.is_aw !== 1'b1) begin
                        errors++; $display("FAIL rr_order round %0d: got AW expected AR", r);
                    end
                end
            end
            bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0;
            checks++;
            if (got !== 2) begin errors++; $display("FAIL rr_grants round %0d: got %0d expected 2", r, got); end
            sb.delete();
            @(negedge aclk);
        end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL rr_single_grant: got %0d overlaps expected 0", overlap); end
    endtask

    task automatic test_bucket_limit();
        bit seen, rdy; int lat, tb4, ta;
        bucket_max = TW'(10); refill_rate = TW'(1);
        @(negedge aclk);
        checks++;
        if (tokens !== TW'(10)) begin errors++; $display("FAIL clamp_tokens: got %0d expected 10", tokens); end
        // Cost 32 exceeds the 10-token bucket: served from a full bucket, leaving refill only.
        for (int n = 0; n < 2; n++) begin
            issue(1'b0, 8'd31, 40, 1'b0, seen, lat, tb4, ta, rdy);
            checks++;
            if (!seen) begin errors++; $display("FAIL big_cost_pass %0d: deadlock, no m_arvalid", n); end
            checks++;
            if (tb4 !== 10) begin errors++; $display("FAIL big_cost_grant %0d: got %0d expected 10", n, tb4); end
            checks++;
            if (ta !== 1) begin errors++; $display("FAIL big_cost_after %0d: got %0d expected 1", n, ta); end
        end
    endtask

    task automatic test_throttle_off();
        bit seen, rdy, reached; int lat, tb4, ta;
        throttle_en = 1'b0; bucket_max = TW'(1000); refill_rate = TW'(1);
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge aclk);
            if (tokens == TW'(5)) reached = 1'b1;
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL tokens_to_5: got %0d expected 5", tokens); end
        issue(1'b1, 8'd255, 20, 1'b0, seen, lat, tb4, ta, rdy);
        checks++;
        if (!seen || lat !== 2) begin
            errors++; $display("FAIL nothrottle_latency: got seen=%0b lat=%0d expected lat=2", seen, lat);
        end
        checks++;
        if (ta !== tb4 + 1) begin errors++; $display("FAIL nothrottle_no_debit: got %0d expected %0d", ta, tb4 + 1); end
        refill_rate = TW'(100);
        repeat (15) @(negedge aclk);
        checks++;
        if (tokens !== TW'(1000)) begin errors++; $display("FAIL nothrottle_fill: got %0d expected 1000", tokens); end
        // Memory side stalls: m_awvalid must hold and s_awready stay low.
        bus.m_awready = 1'b0; bus.s_awlen = 8'd0; bus.s_awvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge aclk);
            seen = bus.m_awvalid;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL stall_pass: m_awvalid not seen within budget"); end
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            checks++;
            if ({bus.m_awvalid, bus.s_awready} !== 2'b10) begin
                errors++; $display("FAIL stall_hold cycle %0d: got %b expected 10", i, {bus.m_awvalid, bus.s_awready});
            end
        end
        bus.m_awready = 1'b1;
        #1;
        checks++;
        if (bus.s_awready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", bus.s_awready); end
        bus.s_awvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if (bus.m_awvalid !== 1'b0) begin errors++; $display("FAIL stall_done: got %b expected 0", bus.m_awvalid); end
        throttle_en = 1'b1;
    endtask

    task automatic test_reset_in_pass();
        bit seen, rdy; int lat, tb4, ta; exp_t e;
        bus.m_arready = 1'b0; bus.s_arlen = 8'd0; bus.s_arvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge aclk);
            seen = bus.m_arvalid;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_pass_reach: m_arvalid not seen within budget"); end
        aresetn = 1'b0; bus.s_arvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({bus.m_arvalid, bus.s_arready} !== 2'b00 || tokens !== '0) begin
            errors++;
            $display("FAIL rst_in_pass: got valid/ready=%b tokens=%0d expected 00 and 0",
                     {bus.m_arvalid, bus.s_arready}, tokens);
        end
        // Release: tokens 4 in COST, 8 in WAIT (>= cost 4), grant, 8+4-4 = 8.
        aresetn = 1'b1; bus.m_arready = 1'b1; refill_rate = TW'(4);
        sb.push_back('{is_aw: 1'b0, value: 4});
        issue(1'b0, 8'd3, 20, 1'b0, seen, lat, tb4, ta, rdy);
        e = sb.pop_front();
        checks++;
        if (!seen || lat !== 2) begin
            errors++; $display("FAIL post_rst_latency: got seen=%0b lat=%0d expected lat=2", seen, lat);
        end
        checks++;
        if (tb4 !== 8 || ta !== 8 || tb4 + 4 - ta !== e.value) begin
            errors++; $display("FAIL post_rst_tokens: got %0d->%0d expected 8->8 (cost %0d)", tb4, ta, e.value);
        end
    endtask

    initial begin
        test_reset();
        test_cost_basic();
        test_penalty();
        test_back_to_back();
        test_round_robin();
        test_bucket_limit();
        test_throttle_off();
        test_reset_in_pass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
